pipeline_stage_reg: RTL and testbench
=====================================

# pipeline_stage_reg

Parametrised, flow-controlled pipeline stage register for the ARM datapath: carries instruction, PC, CPSR flags and write-back enable between two stages, with a valid/ready handshake, a one-entry skid buffer for full throughput under backpressure, synchronous flush for branch squash, and a saturating stall counter. It is inserted at any stage boundary (IF/ID, ID/EX, EX/MEM) where the downstream stage can stall. Unflushed invalid slots present a NOP bubble, so downstream logic without valid-awareness sees a harmless instruction.

## Interface

- INSTR_W, 32, instruction width
- ADDR_W, 32, PC width
- FLAG_W, 4, CPSR flag width (N,Z,C,V)
- NOP_INSTR, 32'hE1A00000, instruction presented while out_valid=0 (MOV r0,r0)
- STALL_CNT_W, 16, stall counter width

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept an entry this cycle
- in_instruction  in  INSTR_W  instruction
- in_pc  in  ADDR_W  PC value
- in_flags  in  FLAG_W  CPSR flags
- in_wb_en  in  1  write-back enable
- out_valid  out  1  output entry present
- out_ready  in  1  downstream accepts output this cycle
- out_instruction  out  INSTR_W  NOP_INSTR when out_valid=0
- out_pc  out  ADDR_W  0 when out_valid=0
- out_flags  out  FLAG_W  0 when out_valid=0
- out_wb_en  out  1  0 when out_valid=0
- stall_count  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation

- Storage: main entry (drives outputs) and skid entry; each has a valid bit.
- States: EMPTY (none valid), ONE (main valid), FULL (main and skid valid).
- out_valid = main valid; in_ready = !skid valid (registered, no combinational path from out_ready).
- fire_in = in_valid & in_ready; fire_out = out_valid & out_ready.
- EMPTY: fire_in -> ONE, main <= input.
- ONE: fire_in & fire_out -> ONE, main <= input; fire_in & !fire_out -> FULL, skid <= input; !fire_in & fire_out -> EMPTY; else hold.
- FULL: fire_out -> ONE, main <= skid; else hold. No input is accepted in FULL.
- flush=1: next state EMPTY regardless of fire_in/fire_out; an input offered in that cycle is dropped. in_ready is still driven from current state (upstream may see its entry "accepted" and discarded — intended squash).
- Invalid entries never drive data: outputs are muxed to NOP_INSTR/0/0/0 whenever main is invalid.
- stall_count increments by 1 each cycle with out_valid=1 & out_ready=0, holds at 2^STALL_CNT_W-1, cleared only by reset; flush does not clear it.
- Entry order strictly preserved; no entry duplicated or lost except by flush.

## Timing

- Reset (reset=0, async): state EMPTY, out_valid=0, in_ready=1, out_instruction=NOP_INSTR, out_pc=0, out_flags=0, out_wb_en=0, stall_count=0. Release is synchronous to the next rising edge.
- Latency: entry accepted at edge N appears on outputs after edge N (visible in cycle N+1).
- Throughput: 1 entry/cycle with out_ready held 1.
- Backpressure: after out_ready drops, at most one further entry is accepted (into skid); in_ready falls the cycle after FULL is entered.
- Recovery: from FULL, out_ready=1 drains main, skid moves to main, in_ready=1 the next cycle.
- Simultaneous flush and fire_out: output entry counts as consumed downstream; stage still goes EMPTY.
- Reset mid-transfer: all entries discarded immediately, no partial output.

## Test plan

- Reset: hold reset=0 with in_valid=1 -> out_valid=0, out_instruction=32'hE1A00000, in_ready=1, stall_count=0.
- Streaming: out_ready=1, feed PCs 0x00,0x04,0x08 on consecutive cycles -> same PCs on out_pc one cycle later each, out_valid=1 for 3 cycles, stall_count stays 0.
- Backpressure: stream PCs 0x10,0x14,0x18, drop out_ready after 0x10 is on output for 3 cycles -> 0x14 captured in skid, in_ready=0, 0x18 held upstream; on out_ready=1 output is 0x10,0x14,0x18 in order; stall_count=3.
- Flush in FULL: state FULL (0x20 main, 0x24 skid), pulse flush with in_valid=1 PC 0x28 -> next cycle out_valid=0, out_wb_en=0, out_instruction=NOP_INSTR; 0x28 never appears.
- Saturation: STALL_CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_count stops at 15.
- Async reset mid-FULL: assert reset=0 between edges -> outputs go to reset values before next edge; after release, fresh stream PC 0x40 emerges with no stale entries.

Source files
------------

// File: rtl/pipeline_stage_reg.sv
// ============================================================================
// Module   : pipeline_stage_reg
// Purpose  : Flow-controlled pipeline stage register with skid buffer, flush
//            and saturating stall counter; presents a NOP when empty.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_stage_reg #(
   parameter int                 INSTR_W     = 32,
   parameter int                 ADDR_W      = 32,
   parameter int                 FLAG_W      = 4,
   parameter logic [INSTR_W-1:0] NOP_INSTR   = 32'hE1A00000,
   parameter int                 STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_W-1:0]     in_instruction,
   input  logic [ADDR_W-1:0]      in_pc,
   input  logic [FLAG_W-1:0]      in_flags,
   input  logic                   in_wb_en,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INSTR_W-1:0]     out_instruction,
   output logic [ADDR_W-1:0]      out_pc,
   output logic [FLAG_W-1:0]      out_flags,
   output logic                   out_wb_en,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam int ENTRY_W = INSTR_W + ADDR_W + FLAG_W + 1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [ENTRY_W-1:0]     main_q, main_d;
   logic [ENTRY_W-1:0]     skid_q, skid_d;
   logic [STALL_CNT_W-1:0] stall_q, stall_d;

   logic                   main_valid;
   logic                   skid_valid;
   logic                   fire_in;
   logic                   fire_out;
   logic [ENTRY_W-1:0]     in_entry;

   assign main_valid = (state_q == ONE) || (state_q == FULL);
   assign skid_valid = (state_q == FULL);

   // in_ready depends only on state, so out_ready never reaches upstream combinationally.
   assign in_ready = !skid_valid;
   assign fire_in  = in_valid && in_ready;
   assign fire_out = main_valid && out_ready;
   assign in_entry = {in_instruction, in_pc, in_flags, in_wb_en};

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (fire_in) begin
               state_d = ONE;
               main_d  = in_entry;
            end
         end
         ONE: begin
            if (fire_in && fire_out) begin
               main_d = in_entry;
            end else if (fire_in) begin
               state_d = FULL;
               skid_d  = in_entry;
            end else if (fire_out) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (fire_out) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Squash wins over any transfer; data registers are don't-care once invalid.
      if (flush) begin
         state_d = EMPTY;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (main_valid && !out_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
         stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         stall_q <= stall_d;
      end
   end

   assign out_valid       = main_valid;
   assign out_instruction = main_valid ? main_q[ENTRY_W-1 -: INSTR_W] : NOP_INSTR;
   assign out_pc          = main_valid ? main_q[FLAG_W+1 +: ADDR_W]   : '0;
   assign out_flags       = main_valid ? main_q[1 +: FLAG_W]          : '0;
   assign out_wb_en       = main_valid ? main_q[0]                    : 1'b0;
   assign stall_count     = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stage_reg.sv
// ============================================================================
// Module   : tb_pipeline_stage_reg
// Purpose  : Directed self-checking bench for pipeline_stage_reg.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_stage_reg;

   localparam int INSTR_W     = 32;
   localparam int ADDR_W      = 32;
   localparam int FLAG_W      = 4;
   localparam int STALL_CNT_W = 4;
   localparam logic [31:0] NOP = 32'hE1A00000;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   flush;
   logic                   in_valid;
   logic                   in_ready;
   logic [INSTR_W-1:0]     in_instruction;
   logic [ADDR_W-1:0]      in_pc;
   logic [FLAG_W-1:0]      in_flags;
   logic                   in_wb_en;
   logic                   out_valid;
   logic                   out_ready;
   logic [INSTR_W-1:0]     out_instruction;
   logic [ADDR_W-1:0]      out_pc;
   logic [FLAG_W-1:0]      out_flags;
   logic                   out_wb_en;
   logic [STALL_CNT_W-1:0] stall_count;

   int checks = 0;
   int errors = 0;

   pipeline_stage_reg #(
      .INSTR_W    (INSTR_W),
      .ADDR_W     (ADDR_W),
      .FLAG_W     (FLAG_W),
      .NOP_INSTR  (NOP),
      .STALL_CNT_W(STALL_CNT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_instruction (in_instruction),
      .in_pc          (in_pc),
      .in_flags       (in_flags),
      .in_wb_en       (in_wb_en),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instruction(out_instruction),
      .out_pc         (out_pc),
      .out_flags      (out_flags),
      .out_wb_en      (out_wb_en),
      .stall_count    (stall_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Instruction and flags are derived from the PC so every field is traceable.
   task automatic offer(input logic v, input logic [31:0] pc);
      in_valid       = v;
      in_pc          = pc;
      in_instruction = {16'hA5A5, pc[15:0]};
      in_flags       = pc[5:2];
      in_wb_en       = 1'b1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
      offer(1'b1, 32'h99);

      // Reset held with an offered entry
      tick(); tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_instr", out_instruction, NOP);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_stall", stall_count, 0);
      reset = 1'b1;
      offer(1'b0, 32'h0);

      // Streaming at full rate
      out_ready = 1'b1;
      offer(1'b1, 32'h00); tick();
      chk("str_v0", out_valid, 1);
      chk("str_pc0", out_pc, 32'h00);
      offer(1'b1, 32'h04); tick();
      chk("str_pc4", out_pc, 32'h04);
      chk("str_instr4", out_instruction, 32'hA5A50004);
      chk("str_flags4", out_flags, 4'h1);
      chk("str_wb4", out_wb_en, 1);
      offer(1'b1, 32'h08); tick();
      chk("str_pc8", out_pc, 32'h08);
      chk("str_v8", out_valid, 1);
      offer(1'b0, 32'h0); tick();
      chk("str_drain_v", out_valid, 0);
      chk("str_drain_pc", out_pc, 0);
      chk("str_stall", stall_count, 0);

      // Backpressure into the skid entry
      offer(1'b1, 32'h10); tick();
      chk("bp_pc10", out_pc, 32'h10);
      out_ready = 1'b0;
      offer(1'b1, 32'h14); tick();
      offer(1'b1, 32'h18);
      chk("bp_in_ready0", in_ready, 0);
      chk("bp_hold10", out_pc, 32'h10);
      chk("bp_stall1", stall_count, 1);
      tick(); tick();
      chk("bp_still10", out_pc, 32'h10);
      chk("bp_stall3", stall_count, 3);
      out_ready = 1'b1; tick();
      chk("bp_pc14", out_pc, 32'h14);
      chk("bp_in_ready1", in_ready, 1);
      tick();
      chk("bp_pc18", out_pc, 32'h18);
      offer(1'b0, 32'h0); tick();
      chk("bp_empty", out_valid, 0);
      chk("bp_stall_end", stall_count, 3);

      // Flush while FULL drops both held entries and the offered one
      out_ready = 1'b0;
      offer(1'b1, 32'h20); tick();
      offer(1'b1, 32'h24); tick();
      chk("fl_full_ready", in_ready, 0);
      chk("fl_main20", out_pc, 32'h20);
      flush = 1'b1;
      offer(1'b1, 32'h28); tick();
      flush = 1'b0;
      chk("fl_valid", out_valid, 0);
      chk("fl_wb", out_wb_en, 0);
      chk("fl_instr", out_instruction, NOP);
      chk("fl_in_ready", in_ready, 1);
      chk("fl_stall_kept", stall_count, 5);
      offer(1'b0, 32'h0); out_ready = 1'b1; tick();
      chk("fl_no28", out_valid, 0);

      // Stall counter saturation
      reset = 1'b0; #1; reset = 1'b1;
      chk("sat_clear", stall_count, 0);
      out_ready = 1'b0;
      offer(1'b1, 32'h30); tick();
      offer(1'b0, 32'h0);
      chk("sat_start", stall_count, 0);
      for (int i = 0; i < 14; i++) tick();
      chk("sat_14", stall_count, 14);
      for (int i = 0; i < 6; i++) tick();
      chk("sat_15", stall_count, 15);
      chk("sat_pc30", out_pc, 32'h30);

      // Asynchronous reset between edges while FULL
      offer(1'b1, 32'h34); tick();
      offer(1'b0, 32'h0);
      chk("ar_full", in_ready, 0);
      #2 reset = 1'b0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_instr", out_instruction, NOP);
      chk("ar_in_ready", in_ready, 1);
      chk("ar_stall", stall_count, 0);
      tick();
      reset = 1'b1;
      out_ready = 1'b1;
      offer(1'b1, 32'h40); tick();
      chk("ar_pc40", out_pc, 32'h40);
      chk("ar_v40", out_valid, 1);
      offer(1'b0, 32'h0); tick();
      chk("ar_no_stale", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
